// File: rtl/fill_readout_sequencer.sv
// Readout-side sequencer: once the channel is out of acquisition, service the
// fill header FIFO one fill at a time. For each header, drive the DDR3 reader,
// wait for completion (or timeout), then pop the header.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for readout permission and a header at the FIFO head
// LATCH     | capture address, burst count and fill number from the header
// ISSUE     | raise enable_reading, clear the read timeout counter
// WAIT_DONE | reader busy; wait for reading_done or timeout
// POP       | drop enable_reading, pop header, pulse fill_done, count fill
// GAP       | wait for reading_done low; lets the FIFO empty flag settle
//
// Register actions in a state take effect on the edge that leaves it, so
// enable_reading is high from WAIT_DONE entry through the POP cycle, and the
// pop / fill_done pulse is visible in the first GAP cycle.
module fill_readout_sequencer #(
    parameter int ADDR_LSB    = 53,
    parameter int CNT_LSB     = 76,
    parameter int FILLNUM_LSB = 0,
    parameter int TIMEOUT_W   = 20
) (
    input  logic         clk125,
    input  logic         reset_clk125,
    input  logic         acq_enabled,
    input  logic         readout_en,
    input  logic         fill_header_fifo_empty,
    input  logic [151:0] fill_header_fifo_out,
    input  logic         reading_done,
    output logic         fill_header_fifo_rd_en,
    output logic [22:0]  ddr3_rd_start_addr,
    output logic [23:0]  ddr3_rd_burst_cnt,
    output logic         enable_reading,
    output logic [23:0]  cur_fill_num,
    output logic         readout_busy,
    output logic         fill_done,
    output logic [15:0]  fills_read,
    output logic         rd_timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LATCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_POP       = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [22:0]            addr_q, addr_d;
    logic [23:0]            cnt_q, cnt_d;
    logic [23:0]            fill_num_q, fill_num_d;
    logic                   en_q, en_d;
    logic                   rd_en_q, rd_en_d;
    logic                   fill_done_q, fill_done_d;
    logic [15:0]            fills_read_q, fills_read_d;
    logic                   err_q, err_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;

    logic [22:0]            hdr_addr;
    logic [23:0]            hdr_cnt;
    logic [23:0]            hdr_fill_num;
    logic [TIMEOUT_W-1:0]   tmo_inc;
    logic                   hdr_unused;

    assign hdr_addr     = fill_header_fifo_out[ADDR_LSB +: 23];
    assign hdr_cnt      = fill_header_fifo_out[CNT_LSB +: 24];
    assign hdr_fill_num = fill_header_fifo_out[FILLNUM_LSB +: 24];
    assign tmo_inc      = tmo_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    // Remaining header fields belong to other consumers of the FIFO.
    assign hdr_unused   = ^fill_header_fifo_out;

    // State and output registers; reset leaves the header in the FIFO.
    always_ff @(posedge clk125 or posedge reset_clk125) begin
        if (reset_clk125) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            fill_num_q   <= '0;
            en_q         <= 1'b0;
            rd_en_q      <= 1'b0;
            fill_done_q  <= 1'b0;
            fills_read_q <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            fill_num_q   <= fill_num_d;
            en_q         <= en_d;
            rd_en_q      <= rd_en_d;
            fill_done_q  <= fill_done_d;
            fills_read_q <= fills_read_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        fill_num_d   = fill_num_q;
        en_d         = en_q;
        rd_en_d      = 1'b0;
        fill_done_d  = 1'b0;
        fills_read_d = fills_read_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        case (state_q)
            S_IDLE: begin
                // reading_done must be low so a stale level is never taken
                // as completion of the next read.
                if (!acq_enabled && readout_en && !fill_header_fifo_empty && !reading_done)
                    state_d = S_LATCH;
            end
            S_LATCH: begin
                addr_d     = hdr_addr;
                cnt_d      = hdr_cnt;
                fill_num_d = hdr_fill_num;
                state_d    = (hdr_cnt == 24'd0) ? S_POP : S_ISSUE;
            end
            S_ISSUE: begin
                en_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (reading_done) begin
                    state_d = S_POP;
                end else begin
                    tmo_d = tmo_inc;
                    if (&tmo_inc) begin
                        err_d   = 1'b1;
                        state_d = S_POP;
                    end
                end
            end
            S_POP: begin
                en_d         = 1'b0;
                rd_en_d      = 1'b1;
                fill_done_d  = 1'b1;
                fills_read_d = fills_read_q + 16'd1;
                state_d      = S_GAP;
            end
            S_GAP: begin
                if (!reading_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fill_header_fifo_rd_en = rd_en_q;
    assign ddr3_rd_start_addr     = addr_q;
    assign ddr3_rd_burst_cnt      = cnt_q;
    assign enable_reading         = en_q;
    assign cur_fill_num           = fill_num_q;
    assign readout_busy           = (state_q != S_IDLE);
    assign fill_done              = fill_done_q;
    assign fills_read             = fills_read_q;
    assign rd_timeout_err         = err_q;

endmodule

// File: doc/fill_readout_sequencer.md
Name: fill_readout_sequencer

Overview:
- Single-clock controller on the readout side of the ADC-to-DDR3 block.
- When the channel leaves acquisition mode, it drains the fill header FIFO one fill at a time. For each header it extracts the DDR3 start address and burst count, drives the DDR3 reader (start address, burst count, enable_reading), waits for reading_done, then pops the header.
- Provides fill-level status (current fill number, done pulse, fill count, timeout error) to the host/readout logic.

Parameters:
- ADDR_LSB, 53: LSB of 23-bit DDR3 start-burst address field in fill_header_fifo_out.
- CNT_LSB, 76: LSB of 24-bit burst-count field in fill_header_fifo_out.
- FILLNUM_LSB, 0: LSB of 24-bit fill-number field in fill_header_fifo_out.
- TIMEOUT_W, 20: width of the read-timeout counter; timeout fires after 2^TIMEOUT_W-1 cycles in WAIT_DONE.

Ports:
- clk125 in 1: readout clock; all logic on rising edge.
- reset_clk125 in 1: asynchronous, active-high reset.
- acq_enabled in 1: channel in acquisition mode; no new reads start while high.
- readout_en in 1: host permission for automatic readout.
- fill_header_fifo_empty in 1: header FIFO empty; the FIFO is first-word-fall-through.
- fill_header_fifo_out in 152: header at FIFO head, valid when not empty.
- reading_done in 1: reader level; high when the requested bursts are read, low after enable_reading drops.
- fill_header_fifo_rd_en out 1: one-cycle pop strobe.
- ddr3_rd_start_addr out 23: first 128-bit burst address to read.
- ddr3_rd_burst_cnt out 24: number of bursts to read.
- enable_reading out 1: reader go, held as a level.
- cur_fill_num out 24: fill number of the header being serviced.
- readout_busy out 1: high in any state other than IDLE.
- fill_done out 1: one-cycle pulse per fill retired.
- fills_read out 16: count of fills retired; wraps at 16'hFFFF -> 0.
- rd_timeout_err out 1: sticky; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; timeout counter 0.
- IDLE -> LATCH when acq_enabled=0 & readout_en=1 & fill_header_fifo_empty=0 & reading_done=0. Otherwise stay.
- LATCH (1 cycle): register addr, cnt and fill number from the header fields into ddr3_rd_start_addr, ddr3_rd_burst_cnt and cur_fill_num.
  - cnt==0 -> POP (no read issued).
  - cnt!=0 -> ISSUE.
- ISSUE (1 cycle): enable_reading<=1; clear the timeout counter; -> WAIT_DONE.
  - Latency: enable_reading rises 2 clocks after the IDLE condition is first sampled true.
- WAIT_DONE:
  - enable_reading held 1; addr and cnt held stable.
  - reading_done=1 -> POP.
  - Else counter increments; at all-ones: rd_timeout_err<=1 -> POP (header discarded).
- POP (1 cycle): enable_reading<=0; fill_header_fifo_rd_en=1; fill_done=1; fills_read+1; -> GAP.
  - fill_done also pulses on timeout and on zero-count fills.
- GAP: stay until reading_done=0 (minimum 1 cycle, covers the FIFO empty-flag update) -> IDLE.
- Exactly one pop per header; never a pop while fill_header_fifo_empty=1.
- A header popped in POP is never re-serviced.
- acq_enabled or readout_en going high mid-read:
  - The current fill runs to completion (no abort).
  - The sequencer returns to IDLE and waits.
- FIFO going empty after LATCH: impossible by construction, since only this block pops. It is not checked.
- Outputs addr/cnt/cur_fill_num retain their last values in IDLE.
- Reset mid-operation: enable_reading drops immediately (async); no pop is issued; the header remains in the FIFO.

Test Plan:
- Single fill: header addr=23'h000040, cnt=24'd10, fill=24'h000055; acq_enabled=0; readout_en=1; reading_done raised 30 cycles after enable_reading.
  - Required: enable_reading at +2 clocks with addr=0x40, cnt=10.
  - Required: one rd_en and one fill_done pulse on the same cycle; fills_read=1; cur_fill_num=0x55.
- Two queued headers (addr 0x0/cnt 4, addr 0x4/cnt 4): two serial reads; enable_reading never overlaps; second ISSUE only after reading_done low; fills_read=2; FIFO empty; return to IDLE.
- Zero-count header:
  - Required: no enable_reading; rd_en and fill_done pulse 2 cycles after LATCH entry; err stays 0.
- Timeout with TIMEOUT_W=4, reading_done never asserted:
  - Required: enable_reading deasserts after 15 WAIT_DONE cycles; rd_timeout_err=1 and stays set; header popped.
- acq_enabled=1 with a non-empty FIFO: no activity. Raise acq_enabled mid-WAIT_DONE: the current read completes and pops, then the block idles until acq_enabled=0.
- Assert reset_clk125 in WAIT_DONE:
  - Required: all outputs 0 immediately; header not popped.
  - Required: after release and restart, the same header is re-serviced.
